// File: rtl/tanh_4bit_quant_feeder_if.sv
// Stream bundle for the tanh quantizing feeder: signed samples in, sign plus 4-bit code out.
// Both directions use valid/ready; the feeder takes the slave view.
interface tanh_4bit_quant_feeder_if #(
  parameter int IN_W = 8
);
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      out_code;
  logic            out_sign;
  logic            out_sat;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_code, out_sign, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_code, out_sign, out_sat, out_valid
  );
endinterface

// File: rtl/tanh_4bit_quant_feeder.sv
// Converts signed samples to sign + saturated 4-bit magnitude code behind a 2-entry skid buffer.
// Optional macro TANH_QUANT_ROUND_EN selects round-half-up instead of truncation when SHIFT>0.
module tanh_4bit_quant_feeder #(
  parameter int IN_W  = 8,
  parameter int SHIFT = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  tanh_4bit_quant_feeder_if.slave bus,
  output logic [CNT_W-1:0]     sat_cnt,
  input  logic                 sat_cnt_clr
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [3:0]      main_code_reg;
  logic            main_sign_reg;
  logic            main_sat_reg;
  logic [3:0]      skid_code_reg;
  logic            skid_sign_reg;
  logic            skid_sat_reg;
  logic [CNT_W-1:0] sat_cnt_reg;

  logic            neg;
  logic [IN_W:0]   ext;
  logic [IN_W:0]   mag;
  logic [IN_W:0]   rnd;
  logic [IN_W:0]   scaled;
  logic            conv_sat;
  logic [3:0]      conv_code;
  logic            conv_sign;
  logic            accept;
  logic            pop;

  // Magnitude is one bit wider than the sample so the most negative value stays exact.
  assign neg = bus.in_data[IN_W-1];
  assign ext = {neg, bus.in_data};
  assign mag = neg ? (~ext + (IN_W+1)'(1)) : ext;

  generate
`ifdef TANH_QUANT_ROUND_EN
    if (SHIFT > 0) begin : g_round
      assign rnd = (IN_W+1)'(1) << (SHIFT - 1);
    end else begin : g_no_round
      assign rnd = '0;
    end
`else
    begin : g_trunc
      assign rnd = '0;
    end
`endif
  endgenerate

  assign scaled    = (mag + rnd) >> SHIFT;
  assign conv_sat  = scaled > (IN_W+1)'(15);
  assign conv_code = conv_sat ? 4'hF : scaled[3:0];
  // A negative value that quantizes to zero is reported as positive zero.
  assign conv_sign = neg & (conv_code != 4'h0);

  assign accept = bus.in_valid & in_ready_reg;
  assign pop    = out_valid_reg & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      main_code_reg <= 4'h0;
      main_sign_reg <= 1'b0;
      main_sat_reg  <= 1'b0;
      skid_code_reg <= 4'h0;
      skid_sign_reg <= 1'b0;
      skid_sat_reg  <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_code_reg <= conv_code;
            main_sign_reg <= conv_sign;
            main_sat_reg  <= conv_sat;
            out_valid_reg <= 1'b1;
            state_reg     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_code_reg <= conv_code;
            main_sign_reg <= conv_sign;
            main_sat_reg  <= conv_sat;
          end else if (accept) begin
            skid_code_reg <= conv_code;
            skid_sign_reg <= conv_sign;
            skid_sat_reg  <= conv_sat;
            in_ready_reg  <= 1'b0;
            state_reg     <= TWO;
          end else if (pop) begin
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            main_code_reg <= skid_code_reg;
            main_sign_reg <= skid_sign_reg;
            main_sat_reg  <= skid_sat_reg;
            in_ready_reg  <= 1'b1;
            state_reg     <= ONE;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over the old count, but a saturating accept in the same cycle still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt_reg <= '0;
    end else if (accept && conv_sat) begin
      if (sat_cnt_clr) begin
        sat_cnt_reg <= CNT_W'(1);
      end else if (sat_cnt_reg != {CNT_W{1'b1}}) begin
        sat_cnt_reg <= sat_cnt_reg + CNT_W'(1);
      end
    end else if (sat_cnt_clr) begin
      sat_cnt_reg <= '0;
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_code  = main_code_reg;
  assign bus.out_sign  = main_sign_reg;
  assign bus.out_sat   = main_sat_reg;
  assign sat_cnt       = sat_cnt_reg;

endmodule

// File: tb/tb_tanh_4bit_quant_feeder.sv
// Directed bench for tanh_4bit_quant_feeder (IN_W=8, SHIFT=1, CNT_W=16).
// Expected values follow the rounding build when TANH_QUANT_ROUND_EN is defined.
module tb_tanh_4bit_quant_feeder;

`ifdef TANH_QUANT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] sat_cnt;
  logic        sat_cnt_clr;
  int          n_vec;
  int          n_err;

  tanh_4bit_quant_feeder_if #(.IN_W(8)) bus ();

  tanh_4bit_quant_feeder #(.IN_W(8), .SHIFT(1), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .sat_cnt     (sat_cnt),
    .sat_cnt_clr (sat_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample for a cycle, then check {valid, code, sign, sat} on the outputs.
  task automatic send(input logic [7:0] d, input logic [3:0] c, input logic s,
                      input logic st, input string tag);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk(tag, {25'd0, bus.out_valid, bus.out_code, bus.out_sign, bus.out_sat},
        {25'd0, 1'b1, c, s, st});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset        = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    sat_cnt_clr  = 1'b0;
    tick();
    tick();
    chk("rst_out", {27'd0, bus.out_valid, bus.out_code},  32'd0);
    chk("rst_flags", {30'd0, bus.out_sign, bus.out_sat}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_cnt", {16'd0, sat_cnt}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic conversion, back-to-back stream with one-cycle latency.
    send(8'h0A, 4'd5, 1'b0, 1'b0, "pos10");
    send(8'hF6, 4'd5, 1'b1, 1'b0, "neg10");
    send(8'h7F, 4'd15, 1'b0, 1'b1, "max_pos");
    send(8'h80, 4'd15, 1'b1, 1'b1, "max_neg");
    send(8'h1E, 4'd15, 1'b0, 1'b0, "edge30");
    tick();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("cnt_two", {16'd0, sat_cnt}, 32'd2);

    // Small negative and the 31 boundary, where rounding changes the result.
    send(8'hFF, RND ? 4'd1 : 4'd0, RND, 1'b0, "neg1");
    send(8'h1F, 4'd15, 1'b0, RND, "edge31");
    tick();
    chk("cnt_edge", {16'd0, sat_cnt}, RND ? 32'd3 : 32'd2);

    // Backpressure: two accepts fill the buffer, third waits.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h02;
    tick();
    chk("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_code1", {28'd0, bus.out_code}, 32'd1);
    bus.in_data = 8'h04;
    tick();
    chk("bp_ready2", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold2", {27'd0, bus.out_valid, bus.out_code}, {27'd0, 1'b1, 4'd1});
    bus.in_data = 8'h06;
    tick();
    chk("bp_hold3", {27'd0, bus.out_valid, bus.out_code}, {27'd0, 1'b1, 4'd1});
    chk("bp_ready3", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("rel_code2", {27'd0, bus.out_valid, bus.out_code}, {27'd0, 1'b1, 4'd2});
    tick();
    bus.in_valid = 1'b0;
    chk("rel_code3", {27'd0, bus.out_valid, bus.out_code}, {27'd0, 1'b1, 4'd3});
    tick();
    chk("rel_empty", {31'd0, bus.out_valid}, 32'd0);

    // Clear, then run the counter up to its ceiling.
    sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("clr_alone", {16'd0, sat_cnt}, 32'd0);
    bus.in_data  = 8'h7F;
    bus.in_valid = 1'b1;
    repeat (65535) tick();
    bus.in_valid = 1'b0;
    chk("cnt_full", {16'd0, sat_cnt}, 32'hFFFF);
    send(8'h80, 4'd15, 1'b1, 1'b1, "cnt_sat_sample");
    chk("cnt_stick", {16'd0, sat_cnt}, 32'hFFFF);
    sat_cnt_clr = 1'b1;
    send(8'h7F, 4'd15, 1'b0, 1'b1, "clr_sample");
    sat_cnt_clr = 1'b0;
    chk("clr_with_sat", {16'd0, sat_cnt}, 32'd1);
    tick();

    // Fill the buffer, then reset asynchronously between edges.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h7F;
    tick();
    tick();
    chk("fill_ready", {31'd0, bus.in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("async_cnt", {16'd0, sat_cnt}, 32'd0);
    chk("async_code", {28'd0, bus.out_code}, 32'd0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_empty", {31'd0, bus.out_valid}, 32'd0);
    send(8'h08, 4'd4, 1'b0, 1'b0, "post_rst_8");
    tick();
    chk("post_rst_drain", {31'd0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
